// File: rtl/data_mem_responder_if.sv
// Data-memory request/response bus between the MEM stage (master) and the
// backing data RAM responder (slave).
interface data_mem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [3:0]  req_be_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        busy_o;

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o
  );

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_be_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, busy_o
  );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: one outstanding load/store against a word RAM with
// LATENCY wait states. Optional DMEM_MISALIGN_ERR_EN flags unaligned accesses.
module data_mem_responder #(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  data_mem_responder_if.slave  bus
);

  localparam int         DEPTH     = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  generate
    if (LATENCY < 0 || LATENCY > 15) begin : gBadLatency
      $error("data_mem_responder: LATENCY must be within 0..15");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, WAIT, RESP} stateT;

  stateT              state, stateNext;
  logic [3:0]         waitCnt, waitCntNext;
  logic               reqReady, accept, commit;
  logic               reqMis;
  logic [ADDR_W-1:0]  reqIdx;

  logic               capWe, capMis;
  logic [ADDR_W-1:0]  capIdx;
  logic [31:0]        capWdata;
  logic [3:0]         capBe;

  logic               cmtWe, cmtMis;
  logic [ADDR_W-1:0]  cmtIdx;
  logic [31:0]        cmtWdata;
  logic [3:0]         cmtBe;

  logic [31:0]        mem [DEPTH];
  logic [31:0]        rspRdata;
  logic               rspErr;
  logic               unusedAddrBits;

  // Ready is forced low while reset is held so nothing is accepted mid-reset.
  assign reqReady = (state == IDLE) && rst_i;
  assign accept   = bus.req_valid_i && reqReady;
  assign reqIdx   = bus.req_addr_i[ADDR_W+1:2];

`ifdef DMEM_MISALIGN_ERR_EN
  assign reqMis = |bus.req_addr_i[1:0];
`else
  assign reqMis = 1'b0;
`endif

  assign unusedAddrBits = ^{bus.req_addr_i[31:ADDR_W+2], bus.req_addr_i[1:0]};

  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 0) begin
            stateNext = RESP;
          end else begin
            stateNext   = WAIT;
            waitCntNext = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        if (waitCnt == 4'd0) stateNext = RESP;
        else                 waitCntNext = waitCnt - 4'd1;
      end
      RESP: begin
        if (bus.rsp_ready_i) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state   <= IDLE;
      waitCnt <= 4'd0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      capWe    <= bus.req_we_i;
      capMis   <= reqMis;
      capIdx   <= reqIdx;
      capWdata <= bus.req_wdata_i;
      capBe    <= bus.req_be_i;
    end
  end

  // With zero wait states the commit edge is the accept edge, so take the live request.
  always_comb begin
    if (state == IDLE) begin
      cmtWe    = bus.req_we_i;
      cmtMis   = reqMis;
      cmtIdx   = reqIdx;
      cmtWdata = bus.req_wdata_i;
      cmtBe    = bus.req_be_i;
    end else begin
      cmtWe    = capWe;
      cmtMis   = capMis;
      cmtIdx   = capIdx;
      cmtWdata = capWdata;
      cmtBe    = capBe;
    end
  end

  assign commit = (stateNext == RESP) && (state != RESP);

  always_ff @(posedge clk_i) begin
    if (commit && cmtWe && !cmtMis) begin
      for (int b = 0; b < 4; b++) begin
        if (cmtBe[b]) mem[cmtIdx][8*b +: 8] <= cmtWdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rspRdata <= 32'd0;
      rspErr   <= 1'b0;
    end else if (commit) begin
      rspRdata <= (cmtWe || cmtMis) ? 32'd0 : mem[cmtIdx];
      rspErr   <= cmtMis;
    end
  end

  assign bus.req_ready_o = reqReady;
  assign bus.rsp_valid_o = (state == RESP);
  assign bus.busy_o      = (state != IDLE);
  assign bus.rsp_rdata_o = rspRdata;
  assign bus.rsp_err_o   = rspErr;

endmodule
